// File: rtl/gauss_filter_gen.sv
// ---------------------------------------------------------------------------
// gauss_filter_gen
//
// Gaussian pulse-shaping FIR (GFSK, BT = 0.5) for the BTLE TX chain. It sits
// between the bit upsampler and the FM/phase accumulator. Each upsampled bit
// is mapped to NRZ (1 -> +coef, 0 -> -coef) and convolved with a symmetric
// odd-length tap set. Only the H = (N+1)/2 unique taps are stored; index H-1
// is the centre tap.
//
// After the last sample of a packet the filter flushes by itself. It injects
// H-1 copies of the final bit so that the tail of the pulse drains out. It
// then clears the history, so the next packet starts from a clean state.
//
// Optional build macro: GAUSS_FILTER_PIPE_EN
//   undefined : single-cycle summation, output latency 1.
//   defined   : the lower-half and upper-half partial sums are registered,
//               then added and saturated. The output latency is 2 for data,
//               valid and valid_last alike. FSM timing, input_drop and
//               tap_wr_err timing do not change.
//
// Ports
//   clk                                  system clock
//   rst                                  synchronous active-high reset
//   tap_wr_en / tap_index / tap_value    tap write port (index 0..H-1)
//   bit_upsample                         input bit
//   bit_upsample_valid                   input bit valid
//   bit_upsample_valid_last              last input of packet (with valid)
//   bit_upsample_gauss_filter            signed filtered sample
//   bit_upsample_gauss_filter_valid      output valid
//   bit_upsample_gauss_filter_valid_last last output of packet (after flush)
//   busy                                 high while flushing
//   input_drop                           pulse: valid input discarded in flush
//   tap_wr_err                           pulse: write to index >= H rejected
// ---------------------------------------------------------------------------
module gauss_filter_gen #(
   parameter int GAUSS_FILTER_BIT_WIDTH = 16,
   parameter int NUM_TAP_GAUSS_FILTER   = 17,
   parameter int TAP_INDEX_WIDTH        = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              tap_wr_en,
   input  logic [TAP_INDEX_WIDTH-1:0]        tap_index,
   input  logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value,
   input  logic                              bit_upsample,
   input  logic                              bit_upsample_valid,
   input  logic                              bit_upsample_valid_last,
   output logic [GAUSS_FILTER_BIT_WIDTH-1:0] bit_upsample_gauss_filter,
   output logic                              bit_upsample_gauss_filter_valid,
   output logic                              bit_upsample_gauss_filter_valid_last,
   output logic                              busy,
   output logic                              input_drop,
   output logic                              tap_wr_err
);

   localparam int W     = GAUSS_FILTER_BIT_WIDTH;
   localparam int N     = NUM_TAP_GAUSS_FILTER;
   localparam int H     = (N + 1) / 2;
   // log2(N) guard bits. N is odd, so N * 2^(W-1) < 2^(ACC_W-1), which
   // means the full sum can never overflow the accumulator.
   localparam int ACC_W = W + $clog2(N);

   localparam logic [TAP_INDEX_WIDTH:0]   H_EXT     = (TAP_INDEX_WIDTH+1)'(H);
   localparam logic [TAP_INDEX_WIDTH-1:0] FLUSH_LEN = TAP_INDEX_WIDTH'(H - 1);
   localparam logic [TAP_INDEX_WIDTH-1:0] CNT_ONE   = TAP_INDEX_WIDTH'(1);

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH
   } state_t;

   genvar gi;

   // ------------------------------------------------------------------
   // Tap storage (unique half plus centre)
   // ------------------------------------------------------------------
   logic signed [W-1:0] tap_q [H];
   logic                tap_idx_bad;

   assign tap_idx_bad = ({1'b0, tap_index} >= H_EXT);

   generate
      for (gi = 0; gi < H; gi++) begin : g_tap
         always_ff @(posedge clk) begin
            if (rst) begin
               tap_q[gi] <= '0;
            end else if (tap_wr_en && (tap_index == TAP_INDEX_WIDTH'(gi))) begin
               tap_q[gi] <= tap_value;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------
   state_t                     state_q;
   logic [TAP_INDEX_WIDTH-1:0] flush_cnt_q;
   logic                       last_bit_q;
   logic [N-2:0]               hist_q;
   logic [N-2:0]               hist_d;
   logic                       tap_wr_err_q;
   logic                       input_drop_q;

   logic in_flush;
   logic accept;      // external sample consumed this cycle
   logic take;        // any sample (external or flush) processed this cycle
   logic flush_end;   // final flush sample: emits valid_last, clears history
   logic cur_bit;

   assign in_flush  = (state_q == ST_FLUSH);
   assign accept    = bit_upsample_valid && !in_flush;
   assign take      = accept || in_flush;
   assign flush_end = in_flush && (flush_cnt_q == CNT_ONE);
   assign cur_bit   = in_flush ? last_bit_q : bit_upsample;

   always_comb begin
      hist_d = hist_q;
      if (flush_end) begin
         hist_d = '0;
      end else if (take) begin
         hist_d = {hist_q[N-3:0], cur_bit};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         flush_cnt_q  <= '0;
         last_bit_q   <= 1'b0;
         hist_q       <= '0;
         tap_wr_err_q <= 1'b0;
         input_drop_q <= 1'b0;
      end else begin
         tap_wr_err_q <= tap_wr_en && tap_idx_bad;
         input_drop_q <= in_flush && bit_upsample_valid;
         hist_q       <= hist_d;
         case (state_q)
            ST_IDLE, ST_RUN: begin
               if (bit_upsample_valid) begin
                  if (bit_upsample_valid_last) begin
                     state_q     <= ST_FLUSH;
                     flush_cnt_q <= FLUSH_LEN;
                     last_bit_q  <= bit_upsample;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_FLUSH: begin
               flush_cnt_q <= flush_cnt_q - 1'b1;
               if (flush_end) begin
                  state_q     <= ST_IDLE;
                  flush_cnt_q <= '0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               flush_cnt_q <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // NRZ-weighted terms. Position k uses x_k = {history, current}[k].
   // Taps are sign-extended before negation, so the most negative tap
   // negates cleanly instead of wrapping.
   // ------------------------------------------------------------------
   logic [N-1:0]            x_vec;
   logic signed [ACC_W-1:0] coef_ext [N];
   logic signed [ACC_W-1:0] term     [N];

   assign x_vec = {hist_q, cur_bit};

   generate
      for (gi = 0; gi < N; gi++) begin : g_term
         localparam int TI = (gi < H) ? gi : (N - 1 - gi);
         assign coef_ext[gi] = {{(ACC_W-W){tap_q[TI][W-1]}}, tap_q[TI]};
         assign term[gi]     = x_vec[gi] ? coef_ext[gi] : -coef_ext[gi];
      end
   endgenerate

   logic signed [ACC_W-1:0] lo_sum;
   logic signed [ACC_W-1:0] hi_sum;

   always_comb begin
      lo_sum = '0;
      hi_sum = '0;
      for (int k = 0; k < H; k++) begin
         lo_sum = lo_sum + term[k];
      end
      for (int k = H; k < N; k++) begin
         hi_sum = hi_sum + term[k];
      end
   end

   function automatic logic [W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX) begin
         return {1'b0, {(W-1){1'b1}}};
      end else if (v < SAT_MIN) begin
         return {1'b1, {(W-1){1'b0}}};
      end else begin
         return v[W-1:0];
      end
   endfunction

   // ------------------------------------------------------------------
   // Output stage(s)
   // ------------------------------------------------------------------
   logic [W-1:0] dout_q;
   logic         dout_valid_q;
   logic         dout_last_q;

`ifdef GAUSS_FILTER_PIPE_EN
   logic signed [ACC_W-1:0] lo_q;
   logic signed [ACC_W-1:0] hi_q;
   logic signed [ACC_W-1:0] total_sum;
   logic                    s1_valid_q;
   logic                    s1_last_q;

   assign total_sum = lo_q + hi_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lo_q         <= '0;
         hi_q         <= '0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
      end else begin
         s1_valid_q   <= take;
         s1_last_q    <= flush_end;
         if (take) begin
            lo_q <= lo_sum;
            hi_q <= hi_sum;
         end
         dout_valid_q <= s1_valid_q;
         dout_last_q  <= s1_last_q;
         if (s1_valid_q) begin
            dout_q <= saturate(total_sum);
         end
      end
   end
`else
   logic signed [ACC_W-1:0] total_sum;

   assign total_sum = lo_sum + hi_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
      end else begin
         dout_valid_q <= take;
         dout_last_q  <= flush_end;
         if (take) begin
            dout_q <= saturate(total_sum);
         end
      end
   end
`endif

   assign bit_upsample_gauss_filter            = dout_q;
   assign bit_upsample_gauss_filter_valid      = dout_valid_q;
   assign bit_upsample_gauss_filter_valid_last = dout_last_q;
   assign busy                                 = in_flush;
   assign input_drop                           = input_drop_q;
   assign tap_wr_err                           = tap_wr_err_q;

endmodule

// File: tb/tb_gauss_filter_gen.sv
module tb_gauss_filter_gen;

   localparam int W   = 16;
   localparam int N   = 17;
   localparam int H   = 9;
   localparam int TIW = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           tap_wr_en = 1'b0;
   logic [TIW-1:0] tap_index = '0;
   logic [W-1:0]   tap_value = '0;
   logic           bit_upsample = 1'b0;
   logic           bit_upsample_valid = 1'b0;
   logic           bit_upsample_valid_last = 1'b0;

   logic [W-1:0]   dout;
   logic           dout_valid;
   logic           dout_last;
   logic           busy;
   logic           input_drop;
   logic           tap_wr_err;

   logic [7:0]     dout8;
   logic           dout8_valid;
   logic           dout8_last;
   logic           busy8;
   logic           input_drop8;
   logic           tap_wr_err8;

   always #5 clk = ~clk;

   gauss_filter_gen #(
      .GAUSS_FILTER_BIT_WIDTH(W),
      .NUM_TAP_GAUSS_FILTER(N),
      .TAP_INDEX_WIDTH(TIW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tap_wr_en(tap_wr_en),
      .tap_index(tap_index),
      .tap_value(tap_value),
      .bit_upsample(bit_upsample),
      .bit_upsample_valid(bit_upsample_valid),
      .bit_upsample_valid_last(bit_upsample_valid_last),
      .bit_upsample_gauss_filter(dout),
      .bit_upsample_gauss_filter_valid(dout_valid),
      .bit_upsample_gauss_filter_valid_last(dout_last),
      .busy(busy),
      .input_drop(input_drop),
      .tap_wr_err(tap_wr_err)
   );

   // Narrow instance for the saturation scenario; shares all stimulus.
   gauss_filter_gen #(
      .GAUSS_FILTER_BIT_WIDTH(8),
      .NUM_TAP_GAUSS_FILTER(N),
      .TAP_INDEX_WIDTH(TIW)
   ) dut8 (
      .clk(clk),
      .rst(rst),
      .tap_wr_en(tap_wr_en),
      .tap_index(tap_index),
      .tap_value(tap_value[7:0]),
      .bit_upsample(bit_upsample),
      .bit_upsample_valid(bit_upsample_valid),
      .bit_upsample_valid_last(bit_upsample_valid_last),
      .bit_upsample_gauss_filter(dout8),
      .bit_upsample_gauss_filter_valid(dout8_valid),
      .bit_upsample_gauss_filter_valid_last(dout8_last),
      .busy(busy8),
      .input_drop(input_drop8),
      .tap_wr_err(tap_wr_err8)
   );

   // ---------------- reference model + scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int m_tap [H];
   bit m_hist [N-1];
   int m_flush_left = 0;
   int exp_q [$];
   bit exp_last_q [$];
   int obs_log [$];
   int out_cnt  = 0;
   int last_cnt = 0;

   function automatic int model_sample(bit x0);
      int s = 0;
      for (int k = 0; k < N; k++) begin
         bit xk;
         int c;
         if (k == 0) xk = x0;
         else        xk = m_hist[k-1];
         if (k < H) c = m_tap[k];
         else       c = m_tap[N-1-k];
         s += xk ? c : -c;
      end
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   function automatic void model_shift(bit x0);
      for (int k = N-2; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = x0;
   endfunction

   function automatic void model_clear_hist();
      for (int k = 0; k < N-1; k++) m_hist[k] = 1'b0;
   endfunction

   function automatic void push_sample(bit x0, bit last);
      exp_q.push_back(model_sample(x0));
      exp_last_q.push_back(last);
      model_shift(x0);
   endfunction

   // Monitor: compare every output against the scoreboard head.
   always @(negedge clk) begin
      if (dout_valid === 1'b1) begin
         out_cnt++;
         obs_log.push_back(int'($signed(dout)));
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected got=%0d last=%0b required=no_output", $signed(dout), dout_last);
         end else begin
            int e;
            bit el;
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            if (dout !== 16'(e) || dout_last !== el)
               $display("FAIL sb_output got=%0d/last=%0b required=%0d/last=%0b", $signed(dout), dout_last, e, el);
            else
               n_pass++;
         end
      end else if (dout_last === 1'b1) begin
         n_checks++;
         $display("FAIL last_without_valid got=1 required=0");
      end
      if (dout_last === 1'b1) last_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(bit v, bit b, bit l);
      bit_upsample_valid      = v;
      bit_upsample            = b;
      bit_upsample_valid_last = l;
      if (m_flush_left > 0) begin
         m_flush_left--;
      end else if (v) begin
         push_sample(b, 1'b0);
         if (l) begin
            for (int i = 0; i < H-1; i++) push_sample(b, i == H-2);
            model_clear_hist();
            m_flush_left = H-1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic write_tap(int idx, int val);
      tap_wr_en = 1'b1;
      tap_index = TIW'(idx);
      tap_value = W'(val);
      if (idx < H) m_tap[idx] = val;
      @(negedge clk);
      tap_wr_en = 1'b0;
   endtask

   task automatic load_ramp_taps();
      for (int i = 0; i < H; i++) write_tap(i, i + 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tap_wr_en = 1'b0;
      bit_upsample_valid = 1'b0;
      bit_upsample_valid_last = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      exp_last_q.delete();
      model_clear_hist();
      for (int i = 0; i < H; i++) m_tap[i] = 0;
      m_flush_left = 0;
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      n_checks++; if (dout !== 16'h0) $display("FAIL reset_data got=%0h required=0", dout); else n_pass++;
      n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got=%0b required=0", dout_valid); else n_pass++;
      n_checks++; if (dout_last !== 1'b0) $display("FAIL reset_last got=%0b required=0", dout_last); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b required=0", busy); else n_pass++;
      n_checks++; if (input_drop !== 1'b0) $display("FAIL reset_drop got=%0b required=0", input_drop); else n_pass++;
      n_checks++; if (tap_wr_err !== 1'b0) $display("FAIL reset_taperr got=%0b required=0", tap_wr_err); else n_pass++;
      n_checks++; if (dout8 !== 8'h0) $display("FAIL reset_data8 got=%0h required=0", dout8); else n_pass++;
      $display("reset: outputs checked");
   endtask

   task automatic test_symmetric();
      do_reset();
      load_ramp_taps();
      obs_log.delete();
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
      idle(4);
      n_checks++; if (obs_log.size() != 20) $display("FAIL sym_ones_count got=%0d required=20", obs_log.size()); else n_pass++;
      n_checks++; if (obs_log[0] != -79) $display("FAIL sym_ones_first got=%0d required=-79", obs_log[0]); else n_pass++;
      n_checks++; if (obs_log[16] != 81) $display("FAIL sym_ones_17th got=%0d required=81", obs_log[16]); else n_pass++;
      n_checks++; if (obs_log[19] != 81) $display("FAIL sym_ones_last got=%0d required=81", obs_log[19]); else n_pass++;
      $display("symmetric ones: out17=%0d", obs_log[16]);
      do_reset();
      load_ramp_taps();
      obs_log.delete();
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0);
      idle(4);
      n_checks++; if (obs_log[19] != -81) $display("FAIL sym_zeros_last got=%0d required=-81", obs_log[19]); else n_pass++;
      $display("symmetric zeros: out20=%0d", obs_log[19]);
   endtask

   task automatic test_impulse();
      do_reset();
      load_ramp_taps();
      obs_log.delete();
      drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 18; i++) drive(1'b1, 1'b0, 1'b0);
      idle(4);
      n_checks++; if (obs_log[0] != -79) $display("FAIL imp_out0 got=%0d required=-79", obs_log[0]); else n_pass++;
      n_checks++; if (obs_log[1] != -77) $display("FAIL imp_out1 got=%0d required=-77", obs_log[1]); else n_pass++;
      n_checks++; if (obs_log[8] != -63) $display("FAIL imp_centre got=%0d required=-63", obs_log[8]); else n_pass++;
      n_checks++; if (obs_log[16] != -79) $display("FAIL imp_out16 got=%0d required=-79", obs_log[16]); else n_pass++;
      n_checks++; if (obs_log[17] != -81) $display("FAIL imp_gone got=%0d required=-81", obs_log[17]); else n_pass++;
      $display("impulse: out0=%0d centre=%0d", obs_log[0], obs_log[8]);
   endtask

   task automatic test_tap_err();
      do_reset();
      load_ramp_taps();
      tap_wr_en = 1'b1;
      tap_index = TIW'(9);
      tap_value = W'(1234);
      @(negedge clk);
      tap_wr_en = 1'b0;
      n_checks++; if (tap_wr_err !== 1'b1) $display("FAIL taperr_pulse got=%0b required=1", tap_wr_err); else n_pass++;
      @(negedge clk);
      n_checks++; if (tap_wr_err !== 1'b0) $display("FAIL taperr_single got=%0b required=0", tap_wr_err); else n_pass++;
      obs_log.delete();
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
      idle(4);
      n_checks++; if (obs_log[19] != 81) $display("FAIL taperr_taps got=%0d required=81", obs_log[19]); else n_pass++;
      $display("tap error: out20=%0d", obs_log[19]);
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < H; i++) write_tap(i, 100);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
      idle(4);
      n_checks++; if (dout8 !== 8'h7F) $display("FAIL sat_pos8 got=%0d required=127", $signed(dout8)); else n_pass++;
      n_checks++; if (dout !== 16'd1700) $display("FAIL sat_wide_pos got=%0d required=1700", $signed(dout)); else n_pass++;
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0);
      idle(4);
      n_checks++; if (dout8 !== 8'h80) $display("FAIL sat_neg8 got=%0d required=-128", $signed(dout8)); else n_pass++;
      n_checks++; if (dout !== 16'hF95C) $display("FAIL sat_wide_neg got=%0d required=-1700", $signed(dout)); else n_pass++;
      $display("saturation: narrow=%0d", $signed(dout8));
   endtask

   task automatic test_flush();
      int busy_cnt = 0;
      int drop_cnt = 0;
      bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      do_reset();
      load_ramp_taps();
      out_cnt = 0;
      last_cnt = 0;
      for (int i = 0; i < 5; i++) drive(1'b1, pat[i], i == 4);
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (busy === 1'b1) busy_cnt++;
         if (input_drop === 1'b1) drop_cnt++;
         if (cyc == 1) drive(1'b1, 1'b1, 1'b0);
         else          drive(1'b0, 1'b0, 1'b0);
      end
      idle(3);
      n_checks++; if (out_cnt != 13) $display("FAIL flush_count got=%0d required=13", out_cnt); else n_pass++;
      n_checks++; if (last_cnt != 1) $display("FAIL flush_last got=%0d required=1", last_cnt); else n_pass++;
      n_checks++; if (busy_cnt != 8) $display("FAIL flush_busy got=%0d required=8", busy_cnt); else n_pass++;
      n_checks++; if (drop_cnt != 1) $display("FAIL flush_drop got=%0d required=1", drop_cnt); else n_pass++;
      $display("flush: outputs=%0d busy_cycles=%0d drops=%0d", out_cnt, busy_cnt, drop_cnt);
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      load_ramp_taps();
      out_cnt = 0;
      last_cnt = 0;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, i == 2);
      idle(2);
      n_checks++; if (busy !== 1'b1) $display("FAIL rmf_busy_before got=%0b required=1", busy); else n_pass++;
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      exp_last_q.delete();
      model_clear_hist();
      for (int i = 0; i < H; i++) m_tap[i] = 0;
      m_flush_left = 0;
      @(negedge clk);
      n_checks++; if (dout !== 16'h0) $display("FAIL rmf_data got=%0h required=0", dout); else n_pass++;
      n_checks++; if (dout_valid !== 1'b0) $display("FAIL rmf_valid got=%0b required=0", dout_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rmf_busy got=%0b required=0", busy); else n_pass++;
      n_checks++; if (last_cnt != 0) $display("FAIL rmf_no_last got=%0d required=0", last_cnt); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      load_ramp_taps();
      obs_log.delete();
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      idle(14);
      n_checks++; if (obs_log[0] != -79) $display("FAIL rmf_clean_first got=%0d required=-79", obs_log[0]); else n_pass++;
      n_checks++; if (last_cnt != 1) $display("FAIL rmf_next_last got=%0d required=1", last_cnt); else n_pass++;
      $display("reset mid-flush: next first=%0d", obs_log[0]);
   endtask

   initial begin
      test_reset();
      test_symmetric();
      test_impulse();
      test_tap_err();
      test_saturation();
      test_flush();
      test_reset_mid_flush();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL sb_drained got=%0d required=0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
